// File: rtl/ovr_i_pkg.sv
// Shared types and constants for the over-current detector: FSM state encoding,
// fault-count width and the saturating counter helper.
package ovr_i_pkg;

  localparam int OVR_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    SENSE  = 2'd2,
    SHTDWN = 2'd3
  } ovr_state_t;

  function automatic logic [OVR_CNT_W-1:0] cnt_sat_inc(input logic [OVR_CNT_W-1:0] c);
    return (c == '1) ? c : c + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ovr_i_sync.sv
// Two-flop synchronizer for one asynchronous comparator flag; both stages clear on reset.
module ovr_i_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ovr_i_detect.sv
// Over-current detector: blanks comparator flags after each PWM_synch, counts consecutive
// faulted PWM periods and latches shutdown. Define OVR_I_SIDE_STATUS_EN to add ovr_side.
module ovr_i_detect
  import ovr_i_pkg::*;
#(
  parameter int BLANK_CYC = 128,
  parameter int OVR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PWM_synch,
  input  logic                 OVR_I_lft,
  input  logic                 OVR_I_rght,
  input  logic                 clr_shtdwn,
  output logic                 ovr_I_blank,
  output logic                 OVR_I_shtdwn,
  output logic [OVR_CNT_W-1:0] ovr_cnt
`ifdef OVR_I_SIDE_STATUS_EN
  ,
  output logic [1:0]           ovr_side
`endif
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC - 1);
  localparam logic [OVR_CNT_W-1:0] LIMIT_CNT = OVR_CNT_W'(OVR_LIMIT);

  ovr_state_t state_reg, state_next;
  logic [BW-1:0] blank_cnt_reg, blank_cnt_next;
  logic [OVR_CNT_W-1:0] cnt_reg, cnt_next, cnt_upd;
  logic fault_reg, fault_next;
  logic blank_reg, blank_d1_reg, blank_d2_reg;
  logic shtdwn_reg;
  logic sensing, fault_now, period_faulted;
  logic [1:0] ovr_raw, ovr_sync, ovr_qual;

  // Bit 1 is the left comparator, bit 0 the right one.
  assign ovr_raw = {OVR_I_lft, OVR_I_rght};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      ovr_i_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ovr_raw[gi]),
        .q     (ovr_sync[gi])
      );
    end
  endgenerate

  // blank_d2 lines the blanking window up with the synchronizer latency.
  assign sensing   = (state_reg == BLANK) || (state_reg == SENSE);
  assign ovr_qual  = (sensing && !blank_d2_reg) ? ovr_sync : 2'b00;
  assign fault_now = |ovr_qual;

  always_comb begin
    state_next     = state_reg;
    blank_cnt_next = blank_cnt_reg;
    cnt_next       = cnt_reg;
    fault_next     = fault_reg;
    period_faulted = fault_reg | fault_now;
    cnt_upd        = period_faulted ? cnt_sat_inc(cnt_reg) : '0;
    case (state_reg)
      IDLE: begin
        fault_next = 1'b0;
        if (PWM_synch) begin
          state_next     = BLANK;
          blank_cnt_next = BLANK_LOAD;
        end
      end
      BLANK, SENSE: begin
        if (PWM_synch) begin
          cnt_next   = cnt_upd;
          fault_next = 1'b0;
          if (period_faulted && (cnt_upd == LIMIT_CNT)) begin
            state_next = SHTDWN;
          end else begin
            state_next     = BLANK;
            blank_cnt_next = BLANK_LOAD;
          end
        end else begin
          fault_next = period_faulted;
          if (state_reg == BLANK) begin
            if (blank_cnt_reg == '0) state_next = SENSE;
            else blank_cnt_next = blank_cnt_reg - BW'(1);
          end
        end
      end
      SHTDWN: begin
        fault_next = 1'b0;
        if (clr_shtdwn) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        fault_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      blank_cnt_reg <= '0;
      cnt_reg       <= '0;
      fault_reg     <= 1'b0;
      blank_reg     <= 1'b0;
      blank_d1_reg  <= 1'b0;
      blank_d2_reg  <= 1'b0;
      shtdwn_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      blank_cnt_reg <= blank_cnt_next;
      cnt_reg       <= cnt_next;
      fault_reg     <= fault_next;
      blank_reg     <= (state_next == BLANK);
      blank_d1_reg  <= blank_reg;
      blank_d2_reg  <= blank_d1_reg;
      shtdwn_reg    <= (state_next == SHTDWN);
    end
  end

  assign ovr_I_blank  = blank_reg;
  assign OVR_I_shtdwn = shtdwn_reg;
  assign ovr_cnt      = cnt_reg;

`ifdef OVR_I_SIDE_STATUS_EN
  logic [1:0] side_flag_reg, side_flag_next;
  logic [1:0] ovr_side_reg, ovr_side_next;

  // Per-period side flags mirror the fault flag; they are latched only on shutdown entry.
  always_comb begin
    side_flag_next = side_flag_reg;
    ovr_side_next  = ovr_side_reg;
    if (state_reg == SHTDWN) begin
      side_flag_next = 2'b00;
      if (clr_shtdwn) ovr_side_next = 2'b00;
    end else if (state_reg == IDLE) begin
      side_flag_next = 2'b00;
    end else if (PWM_synch) begin
      side_flag_next = 2'b00;
      if (state_next == SHTDWN) ovr_side_next = side_flag_reg | ovr_qual;
    end else begin
      side_flag_next = side_flag_reg | ovr_qual;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_flag_reg <= 2'b00;
      ovr_side_reg  <= 2'b00;
    end else begin
      side_flag_reg <= side_flag_next;
      ovr_side_reg  <= ovr_side_next;
    end
  end

  assign ovr_side = ovr_side_reg;
`endif

endmodule

// File: tb/tb_ovr_i_detect.sv
// Randomized and directed checks of ovr_i_detect against a period-level reference model.
module tb_ovr_i_detect;

  localparam int BLANK_CYC = 128;
  localparam int OVR_LIMIT = 3;

  logic       clk;
  logic       rst_n;
  logic       PWM_synch;
  logic       OVR_I_lft;
  logic       OVR_I_rght;
  logic       clr_shtdwn;
  logic       ovr_I_blank;
  logic       OVR_I_shtdwn;
  logic [3:0] ovr_cnt;
`ifdef OVR_I_SIDE_STATUS_EN
  logic [1:0] ovr_side;
`endif

  ovr_i_detect #(
    .BLANK_CYC (BLANK_CYC),
    .OVR_LIMIT (OVR_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PWM_synch    (PWM_synch),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .clr_shtdwn   (clr_shtdwn),
    .ovr_I_blank  (ovr_I_blank),
    .OVR_I_shtdwn (OVR_I_shtdwn),
    .ovr_cnt      (ovr_cnt)
`ifdef OVR_I_SIDE_STATUS_EN
    ,
    .ovr_side     (ovr_side)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which period we are in, how far into blanking, and what has faulted.
  bit       m_active;
  bit       m_shut;
  int       m_cnt;
  int       m_win;
  bit [1:0] m_acc;
  bit [1:0] m_side;
  bit       m_blank;
  // Raw inputs sampled at the last two edges and expected blank after the last three edges.
  bit [1:0] raw_h [0:1];
  bit       blank_h [0:2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_clear();
    m_active = 0; m_shut = 0; m_cnt = 0; m_win = 0;
    m_acc = 0; m_side = 0; m_blank = 0;
    raw_h[0] = 0; raw_h[1] = 0;
    blank_h[0] = 0; blank_h[1] = 0; blank_h[2] = 0;
  endtask

  task automatic check_outputs();
    check_val("blank", ovr_I_blank, m_blank);
    check_val("shtdwn", OVR_I_shtdwn, m_shut);
    check_val("cnt", ovr_cnt, m_cnt);
`ifdef OVR_I_SIDE_STATUS_EN
    check_val("side", ovr_side, m_side);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic synch, input logic [1:0] side, input logic clr);
    bit [1:0] eff;
    PWM_synch  = synch;
    OVR_I_lft  = side[1];
    OVR_I_rght = side[0];
    clr_shtdwn = clr;
    @(posedge clk);
    // A flag sampled two edges ago reaches the qualifier now, judged against blank one edge before that.
    eff = blank_h[2] ? 2'b00 : raw_h[1];
    if (m_shut) begin
      if (clr) begin
        m_shut = 0; m_cnt = 0; m_side = 0; m_acc = 0;
      end
    end else if (!m_active) begin
      if (synch) begin
        m_active = 1; m_acc = 0; m_win = BLANK_CYC;
      end
    end else begin
      m_acc |= eff;
      if (synch) begin
        if (m_acc != 0) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
        else m_cnt = 0;
        if (m_acc != 0 && m_cnt == OVR_LIMIT) begin
          m_shut = 1; m_active = 0; m_side = m_acc;
        end
        m_acc = 0;
        m_win = BLANK_CYC;
      end else if (m_win > 0) begin
        m_win--;
      end
    end
    m_blank = m_active && (m_win > 0);
    raw_h[1] = raw_h[0];
    raw_h[0] = side;
    blank_h[2] = blank_h[1];
    blank_h[1] = blank_h[0];
    blank_h[0] = m_blank;
    #1;
    check_outputs();
  endtask

  task automatic run_period(input int len, input int k1, input logic [1:0] s1,
                            input int k2, input logic [1:0] s2);
    logic [1:0] s;
    step(1'b1, 2'b00, 1'b0);
    for (int i = 1; i < len; i++) begin
      s = 2'b00;
      if (i == k1) s |= s1;
      if (i == k2) s |= s2;
      step(1'b0, s, 1'b0);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    #2;
    PWM_synch = 0; OVR_I_lft = 0; OVR_I_rght = 0; clr_shtdwn = 0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int len, k1, k2;
    logic [1:0] s1, s2;
    rst_n = 1'b0;
    PWM_synch = 0; OVR_I_lft = 0; OVR_I_rght = 0; clr_shtdwn = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;

    // Faults and clear requests before the first PWM_synch are ignored.
    for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 1'b1);
    // Left pulses inside blanking never count.
    for (int p = 0; p < 5; p++) run_period(200, 10, 2'b10, 0, 2'b00);
    // Right pulses outside blanking for three periods trip shutdown.
    for (int p = 0; p < 3; p++) run_period(200, 150, 2'b01, 0, 2'b00);
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) step((i == 4), 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0);
    run_period(200, 0, 2'b00, 0, 2'b00);
    // Faulted, faulted, clean, faulted: the count restarts and no shutdown.
    run_period(200, 140, 2'b01, 0, 2'b00);
    run_period(200, 160, 2'b10, 0, 2'b00);
    run_period(200, 20, 2'b11, 0, 2'b00);
    run_period(200, 180, 2'b11, 0, 2'b00);
    // A fault reaching the qualifier on the PWM_synch edge, and one a clock later.
    run_period(200, 198, 2'b01, 0, 2'b00);
    run_period(200, 199, 2'b10, 0, 2'b00);
    // Short periods restart blanking before it expires.
    for (int p = 0; p < 4; p++) run_period(60, 59, 2'b01, 30, 2'b10);
    run_period(200, 0, 2'b00, 0, 2'b00);
    // Reset mid-blanking with ovr_cnt at 2, then three fresh periods to trip again.
    run_period(200, 150, 2'b01, 0, 2'b00);
    run_period(200, 150, 2'b01, 0, 2'b00);
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 1'b0);
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b0);
    for (int p = 0; p < 3; p++) run_period(200, 170, 2'b01, 0, 2'b00);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    // Left-only faults for three periods.
    for (int p = 0; p < 3; p++) run_period(200, 150, 2'b10, 0, 2'b00);
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);

    // Random periods, pulses, clear requests and an occasional reset.
    for (int p = 0; p < 60; p++) begin
      if (m_shut) begin
        for (int i = 0; i < int'($urandom_range(0, 6)); i++)
          step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'b0);
        step(1'b0, 2'b00, 1'b1);
      end
      if ($urandom_range(0, 29) == 0) apply_reset();
      len = $urandom_range(20, 300);
      k1 = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, len - 1));
      k2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      s1 = 2'($urandom_range(1, 3));
      s2 = 2'($urandom_range(1, 3));
      run_period(len, k1, s1, k2, s2);
      if ($urandom_range(0, 4) == 0) step(1'b0, 2'b00, 1'b1);
    end
    step(1'b1, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
